// File: rtl/coin_acceptor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coin_acceptor_pkg
//  Description : Shared definitions for the vending-machine money path:
//                datapath widths, coin values and acceptor state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package coin_acceptor_pkg;

  localparam int kTotalBits = 31;
  localparam int kNumCoins  = 3;

  // Coin denominations, also used by coin_dispenser
  localparam int unsigned kCoinValue0 = 100;
  localparam int unsigned kCoinValue1 = 500;
  localparam int unsigned kCoinValue2 = 1000;

  // Acceptor session states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RETURN = 2'd2
  } state_t;

  // Value of coin type k; unknown types are worth nothing
  function automatic int unsigned coin_value(input int k);
    case (k)
      0:       return kCoinValue0;
      1:       return kCoinValue1;
      2:       return kCoinValue2;
      default: return 0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/coin_acceptor_coin_value_sum.sv
`default_nettype none
// ============================================================================
//  Module      : coin_value_sum
//  Description : Combinational adder turning a one-bit-per-type coin vector
//                into its total value. One bit wider than the datapath so a
//                full coin vector can never wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_value_sum
  import coin_acceptor_pkg::*;
#(
  parameter int TOTAL_BITS = kTotalBits,
  parameter int NUM_COINS  = kNumCoins
) (
  input  logic [NUM_COINS-1:0]  coins,
  output logic [TOTAL_BITS:0]   sum
);

  localparam int SumW = TOTAL_BITS + 1;

  // Add the value of every coin type present this cycle
  always_comb begin
    sum = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (coins[k]) begin
        sum = sum + SumW'(coin_value(k));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
//  Module      : coin_acceptor
//  Description : Accepts coins, tracks the customer balance, serves purchase
//                deductions and hands the balance to coin_dispenser on a
//                return request or inactivity timeout. All outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int TOTAL_BITS  = kTotalBits,
  parameter int NUM_COINS   = kNumCoins,
  parameter int MAX_BALANCE = 10000,
  parameter int WAIT_TIME   = 100
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_COINS-1:0]             i_input_coin,
  input  logic                             i_deduct_valid,
  input  logic [TOTAL_BITS-1:0]            i_deduct_amount,
  input  logic                             i_trigger_return,
  output logic [TOTAL_BITS-1:0]            o_balance,
  output logic                             o_trigger_return,
  output logic                             o_accept,
  output logic [NUM_COINS-1:0]             o_reject_coin,
  output logic                             o_deduct_ack,
  output logic                             o_deduct_nack,
  output logic [$clog2(WAIT_TIME+1)-1:0]   o_wait_time
);

  localparam int WaitW = $clog2(WAIT_TIME + 1);
  localparam int ExtW  = TOTAL_BITS + 2;
  localparam logic [ExtW-1:0]  MaxBalExt  = ExtW'(MAX_BALANCE);
  localparam logic [WaitW-1:0] WaitReload = WaitW'(WAIT_TIME);

  state_t                 state, state_next;
  logic [TOTAL_BITS:0]    coin_sum;
  logic [TOTAL_BITS-1:0]  balance_next;
  logic [WaitW-1:0]       wait_next;
  logic                   trig_next, accept_next, ack_next, nack_next;
  logic [NUM_COINS-1:0]   reject_next;
  logic [ExtW-1:0]        bal_ext, sum_ext;
  logic                   coins_ok, deduct_ok;

  coin_value_sum #(
    .TOTAL_BITS (TOTAL_BITS),
    .NUM_COINS  (NUM_COINS)
  ) u_coin_value_sum (
    .coins (i_input_coin),
    .sum   (coin_sum)
  );

  // Next-state, next-balance, timer and response pulse computation
  always_comb begin
    state_next   = state;
    balance_next = o_balance;
    wait_next    = o_wait_time;
    trig_next    = 1'b0;
    accept_next  = 1'b0;
    reject_next  = '0;
    ack_next     = 1'b0;
    nack_next    = 1'b0;
    bal_ext      = ExtW'(o_balance);
    sum_ext      = ExtW'(coin_sum);
    // Coin check uses the balance before any deduction of the same cycle
    coins_ok     = (|i_input_coin) && ((bal_ext + sum_ext) <= MaxBalExt);
    deduct_ok    = i_deduct_valid && (i_deduct_amount <= o_balance);

    case (state)
      RETURN: begin
        // Hand-off cycle: dispenser latches o_balance now, session closes
        state_next   = IDLE;
        balance_next = '0;
        wait_next    = '0;
        reject_next  = i_input_coin;
        nack_next    = i_deduct_valid;
      end

      default: begin
        if (i_trigger_return && (o_balance != '0)) begin
          state_next  = RETURN;
          trig_next   = 1'b1;
          wait_next   = '0;
          reject_next = i_input_coin;
          nack_next   = i_deduct_valid;
        end else begin
          accept_next  = coins_ok;
          reject_next  = ((|i_input_coin) && !coins_ok) ? i_input_coin : '0;
          ack_next     = deduct_ok;
          nack_next    = i_deduct_valid && !deduct_ok;
          balance_next = TOTAL_BITS'(bal_ext
                                     + (coins_ok  ? sum_ext : '0)
                                     - (deduct_ok ? ExtW'(i_deduct_amount) : '0));
          if (coins_ok || deduct_ok) begin
            // Activity beats a timer that would expire this cycle
            if (balance_next == '0) begin
              state_next = IDLE;
              wait_next  = '0;
            end else begin
              state_next = ACTIVE;
              wait_next  = WaitReload;
            end
          end else if (state == ACTIVE) begin
            if (o_wait_time == WaitW'(1)) begin
              state_next = RETURN;
              trig_next  = 1'b1;
              wait_next  = '0;
            end else if (o_wait_time != '0) begin
              wait_next = o_wait_time - WaitW'(1);
            end
          end else begin
            wait_next = '0;
          end
        end
      end
    endcase
  end

  // State and output registers; reset discards any held balance
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      o_balance        <= '0;
      o_wait_time      <= '0;
      o_trigger_return <= 1'b0;
      o_accept         <= 1'b0;
      o_reject_coin    <= '0;
      o_deduct_ack     <= 1'b0;
      o_deduct_nack    <= 1'b0;
    end else begin
      state            <= state_next;
      o_balance        <= balance_next;
      o_wait_time      <= wait_next;
      o_trigger_return <= trig_next;
      o_accept         <= accept_next;
      o_reject_coin    <= reject_next;
      o_deduct_ack     <= ack_next;
      o_deduct_nack    <= nack_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_acceptor
//  Description : Directed-vector bench for coin_acceptor (WAIT_TIME=8). The
//                driver pushes the hand-computed response of every cycle into
//                a queue; a monitor pops and compares after each clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_acceptor;

  localparam int TB_BITS  = 31;
  localparam int TB_COINS = 3;
  localparam int TB_WAIT  = 8;
  localparam int TB_WW    = $clog2(TB_WAIT + 1);

  typedef struct packed {
    logic [TB_BITS-1:0]  bal;
    logic                trig;
    logic                acc;
    logic [TB_COINS-1:0] rej;
    logic                ack;
    logic                nack;
    logic [TB_WW-1:0]    wt;
    int unsigned         tag;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [TB_COINS-1:0]  input_coin = '0;
  logic                 deduct_valid = 1'b0;
  logic [TB_BITS-1:0]   deduct_amount = '0;
  logic                 trigger_in = 1'b0;
  logic [TB_BITS-1:0]   balance;
  logic                 trigger_out, accept, deduct_ack, deduct_nack;
  logic [TB_COINS-1:0]  reject_coin;
  logic [TB_WW-1:0]     wait_time;

  exp_t        exp_q[$];
  int unsigned step_id = 0;
  int          checks = 0;
  int          failures = 0;

  coin_acceptor #(
    .TOTAL_BITS  (TB_BITS),
    .NUM_COINS   (TB_COINS),
    .MAX_BALANCE (10000),
    .WAIT_TIME   (TB_WAIT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_input_coin     (input_coin),
    .i_deduct_valid   (deduct_valid),
    .i_deduct_amount  (deduct_amount),
    .i_trigger_return (trigger_in),
    .o_balance        (balance),
    .o_trigger_return (trigger_out),
    .o_accept         (accept),
    .o_reject_coin    (reject_coin),
    .o_deduct_ack     (deduct_ack),
    .o_deduct_nack    (deduct_nack),
    .o_wait_time      (wait_time)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int unsigned bal, input logic trig, input logic acc,
                              input logic [TB_COINS-1:0] rej, input logic ack,
                              input logic nack, input int unsigned wt);
    exp_t e;
    e.bal  = TB_BITS'(bal);
    e.trig = trig;
    e.acc  = acc;
    e.rej  = rej;
    e.ack  = ack;
    e.nack = nack;
    e.wt   = TB_WW'(wt);
    e.tag  = 0;
    return e;
  endfunction

  // Drive one cycle of stimulus and queue the response expected after the edge
  task automatic step(input logic rst, input logic [TB_COINS-1:0] c, input logic dv,
                      input int unsigned amt, input logic tr, input exp_t e);
    exp_t ex;
    @(negedge clk);
    reset         = rst;
    input_coin    = c;
    deduct_valid  = dv;
    deduct_amount = TB_BITS'(amt);
    trigger_in    = tr;
    step_id       = step_id + 1;
    ex            = e;
    ex.tag        = step_id;
    exp_q.push_back(ex);
  endtask

  task automatic idle(input exp_t e);
    step(1'b0, 3'b000, 1'b0, 0, 1'b0, e);
  endtask

  // Monitor: every registered output set is compared just after the edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks = checks + 1;
      if (balance !== e.bal || trigger_out !== e.trig || accept !== e.acc ||
          reject_coin !== e.rej || deduct_ack !== e.ack || deduct_nack !== e.nack ||
          wait_time !== e.wt) begin
        failures = failures + 1;
        $display("FAIL step%0d: got bal=%0d trig=%b acc=%b rej=%b ack=%b nack=%b wt=%0d, required bal=%0d trig=%b acc=%b rej=%b ack=%b nack=%b wt=%0d",
                 e.tag, balance, trigger_out, accept, reject_coin, deduct_ack, deduct_nack,
                 wait_time, e.bal, e.trig, e.acc, e.rej, e.ack, e.nack, e.wt);
      end
    end
  end

  initial begin
    // Reset state
    step(1'b1, 3'b000, 1'b0, 0, 1'b0, mk(0, 0, 0, 3'b000, 0, 0, 0));
    step(1'b1, 3'b000, 1'b0, 0, 1'b0, mk(0, 0, 0, 3'b000, 0, 0, 0));

    // Consecutive coin inserts
    step(1'b0, 3'b010, 1'b0, 0, 1'b0, mk(500, 0, 1, 3'b000, 0, 0, 8));
    step(1'b0, 3'b100, 1'b0, 0, 1'b0, mk(1500, 0, 1, 3'b000, 0, 0, 8));

    // Over-balance deduction refused, exact deduction empties session
    step(1'b0, 3'b000, 1'b1, 2000, 1'b0, mk(1500, 0, 0, 3'b000, 0, 1, 7));
    step(1'b0, 3'b000, 1'b1, 1500, 1'b0, mk(0, 0, 0, 3'b000, 1, 0, 0));
    idle(mk(0, 0, 0, 3'b000, 0, 0, 0));

    // Return button with zero balance is ignored
    step(1'b0, 3'b000, 1'b0, 0, 1'b1, mk(0, 0, 0, 3'b000, 0, 0, 0));

    // Inactivity timeout: 8 cycles after the accept
    step(1'b0, 3'b001, 1'b0, 0, 1'b0, mk(100, 0, 1, 3'b000, 0, 0, 8));
    for (int i = 7; i >= 1; i--) idle(mk(100, 0, 0, 3'b000, 0, 0, i));
    idle(mk(100, 1, 0, 3'b000, 0, 0, 0));
    idle(mk(0, 0, 0, 3'b000, 0, 0, 0));

    // Fill to 9500, then MAX_BALANCE boundary
    for (int i = 1; i <= 6; i++) step(1'b0, 3'b110, 1'b0, 0, 1'b0, mk(1500 * i, 0, 1, 3'b000, 0, 0, 8));
    step(1'b0, 3'b010, 1'b0, 0, 1'b0, mk(9500, 0, 1, 3'b000, 0, 0, 8));
    step(1'b0, 3'b110, 1'b0, 0, 1'b0, mk(9500, 0, 0, 3'b110, 0, 0, 7));
    step(1'b0, 3'b010, 1'b0, 0, 1'b0, mk(10000, 0, 1, 3'b000, 0, 0, 8));
    step(1'b0, 3'b001, 1'b0, 0, 1'b0, mk(10000, 0, 0, 3'b001, 0, 0, 7));
    step(1'b0, 3'b000, 1'b1, 10000, 1'b0, mk(0, 0, 0, 3'b000, 1, 0, 0));

    // Return together with coin and deduction
    step(1'b0, 3'b011, 1'b0, 0, 1'b0, mk(600, 0, 1, 3'b000, 0, 0, 8));
    step(1'b0, 3'b001, 1'b1, 100, 1'b1, mk(600, 1, 0, 3'b001, 0, 1, 0));
    idle(mk(0, 0, 0, 3'b000, 0, 0, 0));

    // Coins and deduction presented during the RETURN cycle
    step(1'b0, 3'b011, 1'b0, 0, 1'b0, mk(600, 0, 1, 3'b000, 0, 0, 8));
    step(1'b0, 3'b000, 1'b0, 0, 1'b1, mk(600, 1, 0, 3'b000, 0, 0, 0));
    step(1'b0, 3'b100, 1'b1, 50, 1'b0, mk(0, 0, 0, 3'b100, 0, 1, 0));
    idle(mk(0, 0, 0, 3'b000, 0, 0, 0));

    // Simultaneous accept and ack, then accept on the would-expire cycle
    step(1'b0, 3'b100, 1'b0, 0, 1'b0, mk(1000, 0, 1, 3'b000, 0, 0, 8));
    step(1'b0, 3'b010, 1'b1, 300, 1'b0, mk(1200, 0, 1, 3'b000, 1, 0, 8));
    for (int i = 7; i >= 1; i--) idle(mk(1200, 0, 0, 3'b000, 0, 0, i));
    step(1'b0, 3'b001, 1'b0, 0, 1'b0, mk(1300, 0, 1, 3'b000, 0, 0, 8));

    // Mid-session reset discards balance, no return pulse
    step(1'b0, 3'b000, 1'b1, 200, 1'b0, mk(1100, 0, 0, 3'b000, 1, 0, 8));
    step(1'b1, 3'b001, 1'b1, 100, 1'b1, mk(0, 0, 0, 3'b000, 0, 0, 0));
    idle(mk(0, 0, 0, 3'b000, 0, 0, 0));
    step(1'b0, 3'b000, 1'b0, 0, 1'b1, mk(0, 0, 0, 3'b000, 0, 0, 0));

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain: got %0d pending responses, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Input side of the vending-machine money path. Accepts inserted coins, keeps the customer balance, and serves deduction requests from item selection. It ends a session on a manual return request or an inactivity timeout by handing the balance to coin_dispenser through the balance/trigger interface that coin_dispenser consumes.

Parameters:
TOTAL_BITS, 31, width of balance and amount datapaths (matches `kTotalBits)
NUM_COINS, 3, number of coin types (matches `kNumCoins)
MAX_BALANCE, 10000, highest balance allowed; coins that would exceed it are rejected
WAIT_TIME, 100, inactivity cycles before automatic return

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_input_coin  in  NUM_COINS  bit k = one coin of type k inserted this cycle; several bits may be set
i_deduct_valid  in  1  purchase deduction request, single-cycle
i_deduct_amount  in  TOTAL_BITS  amount to deduct; sampled when i_deduct_valid=1
i_trigger_return  in  1  customer return button, single-cycle
o_balance  out  TOTAL_BITS  current balance; feeds coin_dispenser.balance
o_trigger_return  out  1  one-cycle pulse; feeds coin_dispenser.i_trigger_return
o_accept  out  1  one-cycle pulse: previous cycle's coins were credited
o_reject_coin  out  NUM_COINS  one-cycle echo of the coins rejected in the previous cycle
o_deduct_ack  out  1  one-cycle pulse: deduction performed
o_deduct_nack  out  1  one-cycle pulse: deduction refused
o_wait_time  out  clog2(WAIT_TIME+1)  remaining inactivity cycles

Behaviour:
- Clocking and reset: all state updates on posedge clk; reset is synchronous, active-high. Reset has priority over every other input, including mid-session. On reset:
  - state=IDLE, o_balance=0, o_wait_time=0
  - all pulse outputs (o_trigger_return, o_accept, o_deduct_ack, o_deduct_nack) =0, o_reject_coin=0
  - a balance held at reset is discarded.
- Coin values: type0=100, type1=500, type2=1000.
- Coin sum: coin_sum = Σ i_input_coin[k]·value[k], computed at TOTAL_BITS+1 bits. No wrap is permitted.
- Every output is registered. Each response appears on the cycle after its stimulus, and each pulse lasts exactly 1 cycle.
- States:
  - IDLE: balance==0.
  - ACTIVE: balance>0.
  - RETURN: one-cycle hand-off.
- Priority in IDLE/ACTIVE, evaluated each cycle:
  1. i_trigger_return with balance!=0: go to RETURN. Coins that cycle are rejected; a deduction that cycle is nacked.
  2. Coins and deduction are evaluated together against the current balance B:
     - Deduction OK iff amount<=B. OK gives ack; otherwise nack, and the amount is not subtracted.
     - Coins accepted iff B+coin_sum<=MAX_BALANCE. The check uses B before the deduction. Rejected coins give o_reject_coin=i_input_coin and B is unchanged by them.
     - Next balance = B + (accepted ? coin_sum : 0) − (ack ? amount : 0).
  3. Timeout: in ACTIVE, if no accept or ack occurred this cycle and o_wait_time==1, go to RETURN.
- i_trigger_return with balance==0 is ignored and no pulse is emitted.
- Timer:
  - Reloaded to WAIT_TIME on every coin accept or deduct ack.
  - Decrements by 1 per cycle in ACTIVE otherwise.
  - Set to 0 in IDLE and RETURN.
  - Accept or ack in the cycle the timer would expire wins: reload, no return.
- ACTIVE to IDLE: an ack that brings balance to 0 moves to IDLE directly. No return is issued.
- RETURN (exactly 1 cycle):
  - o_trigger_return=1, with o_balance still holding the session balance for coin_dispenser to latch.
  - Coins presented in RETURN are rejected; a deduction is nacked.
  - Next cycle: o_balance=0, state=IDLE.
- o_reject_coin and o_accept are never both nonzero in the same cycle.

Decomposition:
- Shared package/def file holds:
  - kTotalBits, kNumCoins
  - coin value constants 100/500/1000 (shared with coin_dispenser)
  - state encoding localparams IDLE/ACTIVE/RETURN
- One natural sub-module: coin_value_sum, a combinational coin-vector-to-value adder, reusable by coin_dispenser.
- Timer and FSM stay in coin_acceptor.

Test Plan:
1. Reset, then insert type1, then type2 on consecutive cycles. Required: o_accept pulses, o_balance=500 then 1500, o_wait_time reloads to WAIT_TIME.
2. With balance=9500 (MAX_BALANCE=10000), insert type2 and type1 together. Required: o_reject_coin=3'b110 for 1 cycle, o_accept=0, balance stays 9500. Then insert type1 alone: accepted, balance=10000.
3. Balance=1500: deduct 2000, then deduct 1500. Required: nack with balance 1500; then ack with balance 0, state IDLE, o_trigger_return never pulses.
4. WAIT_TIME=8, insert type0, no further activity. Required: exactly 8 cycles later o_trigger_return=1 with o_balance=100. Next cycle o_balance=0.
5. Balance=600: assert i_trigger_return together with a type0 coin and a deduct of 100. Required: RETURN pulse with o_balance=600, o_reject_coin=3'b001, o_deduct_nack=1, then balance 0.
6. Balance=1100: assert reset for 1 cycle mid-session. Required: all outputs at reset values next cycle, no o_trigger_return. Also: i_trigger_return in IDLE produces no pulse.
